// File: rtl/mul_seq_32.sv
// Sequential unsigned 32x32->64 shift-add multiplier built around a ripple-carry
// add/sub unit; START/DONE handshake toward the control unit.

module faCell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

module RC_ADD_SUB_32 #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             SnA,
  output logic [WIDTH-1:0] Y,
  output logic             CO
);
  logic [WIDTH:0] carry;

  // SnA=1 turns the chain into A + ~B + 1
  assign carry[0] = SnA;
  generate
    for (genvar i = 0; i < WIDTH; i++) begin : gBit
      faCell uFa (
        .a (A[i]),
        .b (B[i] ^ SnA),
        .ci(carry[i]),
        .s (Y[i]),
        .co(carry[i+1])
      );
    end
  endgenerate
  assign CO = carry[WIDTH];
endmodule

module mul_seq_32 #(
  parameter bit ZERO_SKIP  = 1'b1,
  parameter int ITER_COUNT = 32
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        START,
  input  logic [31:0] OP1,
  input  logic [31:0] OP2,
  output logic        BUSY,
  output logic        DONE,
  output logic [31:0] HI,
  output logic [31:0] LO
);
  localparam int CW = $clog2(ITER_COUNT);

  typedef enum logic [1:0] {IDLE, ITER, FIN} state_t;

  state_t          state;
  logic [31:0]     mcand, hi, lo;
  logic [31:0]     addB, addY;
  logic            addCo;
  logic [CW-1:0]   iterCnt;
  logic            zeroOp;
  logic            busy, done;

  assign addB   = lo[0] ? mcand : '0;
  assign zeroOp = ZERO_SKIP && ((OP1 == '0) || (OP2 == '0));

  RC_ADD_SUB_32 uAdd (
    .A  (hi),
    .B  (addB),
    .SnA(1'b0),
    .Y  (addY),
    .CO (addCo)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state   <= IDLE;
      mcand   <= '0;
      hi      <= '0;
      lo      <= '0;
      iterCnt <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      case (state)
        ITER: begin
          // {CO,Y,LO[31:1]}: right shift with the adder carry entering bit 63
          hi      <= {addCo, addY[31:1]};
          lo      <= {addY[0], lo[31:1]};
          iterCnt <= iterCnt + 1'b1;
          if (iterCnt == CW'(ITER_COUNT - 1)) begin
            state <= FIN;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: begin
          done <= 1'b0;
          busy <= 1'b0;
          if (START) begin
            mcand   <= OP1;
            iterCnt <= '0;
            hi      <= '0;
            if (zeroOp) begin
              lo    <= '0;
              state <= FIN;
              done  <= 1'b1;
            end else begin
              lo    <= OP2;
              state <= ITER;
              busy  <= 1'b1;
            end
          end else begin
            state <= IDLE;
          end
        end
      endcase
    end
  end

  assign BUSY = busy;
  assign DONE = done;
  assign HI   = hi;
  assign LO   = lo;
endmodule

// File: tb/tb_mul_seq_32.sv
// Scoreboard bench for mul_seq_32: drivers push expected product and DONE cycle,
// per-DUT monitors pop and compare whenever DONE is seen.

module tb_mul_seq_32;
  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        START = 1'b0, START0 = 1'b0;
  logic [31:0] OP1 = '0, OP2 = '0;
  logic        BUSY, DONE, BUSY0, DONE0;
  logic [31:0] HI, LO, HI0, LO0;

  typedef struct {
    logic [63:0] prod;
    int unsigned cyc;
  } exp_t;

  exp_t        q1[$], q0[$];
  int unsigned cyc = 0;
  int          checks = 0, passes = 0;

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  mul_seq_32 #(.ZERO_SKIP(1'b1)) dut (
    .CLK(CLK), .RST(RST), .START(START), .OP1(OP1), .OP2(OP2),
    .BUSY(BUSY), .DONE(DONE), .HI(HI), .LO(LO)
  );

  mul_seq_32 #(.ZERO_SKIP(1'b0)) dut0 (
    .CLK(CLK), .RST(RST), .START(START0), .OP1(OP1), .OP2(OP2),
    .BUSY(BUSY0), .DONE(DONE0), .HI(HI0), .LO(LO0)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h, expected %h", nm, act, exp);
  endtask

  // monitors
  always @(negedge CLK) begin
    if (DONE) begin
      if (q1.size() == 0) chk("dut unexpected DONE", 64'd1, 64'd0);
      else begin
        exp_t e;
        e = q1.pop_front();
        chk("dut product", {HI, LO}, e.prod);
        chk("dut DONE cycle", 64'(cyc), 64'(e.cyc));
      end
    end
  end

  always @(negedge CLK) begin
    if (DONE0) begin
      if (q0.size() == 0) chk("dut0 unexpected DONE", 64'd1, 64'd0);
      else begin
        exp_t e;
        e = q0.pop_front();
        chk("dut0 product", {HI0, LO0}, e.prod);
        chk("dut0 DONE cycle", 64'(cyc), 64'(e.cyc));
      end
    end
  end

  // Returns at the negedge right after the accepting edge.
  task automatic startOp(input bit sel0, input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] prod, input bit skip);
    exp_t e;
    @(negedge CLK);
    if (sel0) START0 = 1'b1; else START = 1'b1;
    OP1 = a;
    OP2 = b;
    e.prod = prod;
    e.cyc  = cyc + 1 + (skip ? 0 : 32);
    if (sel0) q0.push_back(e); else q1.push_back(e);
    @(negedge CLK);
    START = 1'b0;
    START0 = 1'b0;
    OP1 = $urandom;
    OP2 = $urandom;
  endtask

  task automatic waitDone(input bit sel0, input int maxCyc, output int busyCnt);
    bit seen = 1'b0;
    busyCnt = int'(sel0 ? BUSY0 : BUSY);
    for (int i = 0; i < maxCyc; i++) begin
      if (sel0 ? DONE0 : DONE) begin seen = 1'b1; break; end
      @(negedge CLK);
      if (!(sel0 ? DONE0 : DONE) && (sel0 ? BUSY0 : BUSY)) busyCnt++;
    end
    if (!seen && (sel0 ? DONE0 : DONE)) seen = 1'b1;
    if (!seen) chk("DONE timeout", 64'd0, 64'd1);
  endtask

  initial begin
    int bc;
    // reset state
    repeat (3) @(negedge CLK);
    chk("reset BUSY", 64'(BUSY), 64'd0);
    chk("reset DONE", 64'(DONE), 64'd0);
    chk("reset HI", 64'(HI), 64'd0);
    chk("reset LO", 64'(LO), 64'd0);
    RST = 1'b0;
    @(negedge CLK);

    // 9*8, BUSY duration
    startOp(1'b0, 32'd9, 32'd8, 64'd72, 1'b0);
    waitDone(1'b0, 60, bc);
    chk("9*8 BUSY cycles", 64'(bc), 64'd32);
    chk("BUSY low at DONE", 64'(BUSY), 64'd0);
    @(negedge CLK);
    chk("DONE one cycle", 64'(DONE), 64'd0);
    chk("HI/LO hold after DONE", {HI, LO}, 64'd72);

    // carry into bit 63
    startOp(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 1'b0);
    waitDone(1'b0, 60, bc);
    @(negedge CLK);

    // zero operand with and without skipping
    startOp(1'b0, 32'd0, 32'd5, 64'd0, 1'b1);
    chk("zero-skip BUSY", 64'(BUSY), 64'd0);
    @(negedge CLK);
    startOp(1'b1, 32'd0, 32'd5, 64'd0, 1'b0);
    waitDone(1'b1, 60, bc);
    chk("no-skip BUSY cycles", 64'(bc), 64'd32);
    @(negedge CLK);

    // START during ITER is ignored
    startOp(1'b0, 32'd9, 32'd8, 64'd72, 1'b0);
    repeat (9) @(negedge CLK);
    START = 1'b1; OP1 = 32'd3; OP2 = 32'd3;
    @(negedge CLK);
    START = 1'b0;
    waitDone(1'b0, 60, bc);
    repeat (3) @(negedge CLK);

    // asynchronous reset mid-operation
    startOp(1'b0, 32'h0001_0000, 32'h0001_0000, 64'h1_0000_0000, 1'b0);
    repeat (15) @(negedge CLK);
    void'(q1.pop_back());
    #1 RST = 1'b1;
    #1;
    chk("async rst BUSY", 64'(BUSY), 64'd0);
    chk("async rst DONE", 64'(DONE), 64'd0);
    chk("async rst HI/LO", {HI, LO}, 64'd0);
    @(negedge CLK);
    RST = 1'b0;
    startOp(1'b0, 32'd5, 32'd5, 64'd25, 1'b0);
    waitDone(1'b0, 60, bc);
    @(negedge CLK);

    // back-to-back through the DONE cycle
    startOp(1'b0, 32'd9, 32'd8, 64'd72, 1'b0);
    repeat (31) @(negedge CLK);
    startOp(1'b0, 32'd7, 32'd6, 64'd42, 1'b0);
    chk("b2b BUSY after DONE", 64'(BUSY), 64'd1);
    waitDone(1'b0, 60, bc);
    repeat (4) @(negedge CLK);

    chk("dut queue drained", 64'(q1.size()), 64'd0);
    chk("dut0 queue drained", 64'(q0.size()), 64'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
